// File: rtl/inpr_uart_rx.sv
// 8N1 serial receiver feeding the basic computer's INPR register and FGI flag.
// RX is double-synchronized; each frame is mid-bit sampled with a bit-time counter.
module inpr_uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RX,
   input  logic       FGI_CLR,
   output logic [7:0] INPR,
   output logic       FGI,
   output logic       OVR,
   output logic       FERR,
   output logic       BUSY
);

   localparam int            H        = CLKS_PER_BIT / 2;
   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [2:0]    idx_q,   idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    inpr_q,  inpr_d;
   logic          fgi_q,   fgi_d;
   logic          ovr_q,   ovr_d;
   logic          ferr_q,  ferr_d;
   logic          busy_q,  busy_d;

   logic rx_s;
   logic deliver;
   logic frame_bad;

   assign rx_s = sync2_q;

   always_comb begin
      // NOTE: every _d takes its held value first, so no path through this block can infer a latch.
      sync1_d   = RX;
      sync2_d   = sync1_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      inpr_d    = inpr_q;
      fgi_d     = fgi_q;
      ovr_d     = ovr_q;
      ferr_d    = ferr_q;
      deliver   = 1'b0;
      frame_bad = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               idx_d   = 3'd0;
               state_d = rx_s ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               if (idx_q == 3'd7) state_d = S_STOP;
               else               idx_d   = idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  deliver = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  frame_bad = 1'b1;
                  state_d   = S_WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT_HIGH: begin
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A delivery coinciding with the acknowledge counts as reading the old character.
      if (deliver) begin
         if (!fgi_q || FGI_CLR) begin
            inpr_d = shift_q;
            fgi_d  = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
         if (FGI_CLR) begin
            ovr_d  = 1'b0;
            ferr_d = 1'b0;
         end
      end else if (FGI_CLR) begin
         fgi_d  = 1'b0;
         ovr_d  = 1'b0;
         ferr_d = 1'b0;
      end
      if (frame_bad) ferr_d = 1'b1;

      busy_d = (state_d != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         shift_q <= 8'h00;
         inpr_q  <= 8'h00;
         fgi_q   <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         inpr_q  <= inpr_d;
         fgi_q   <= fgi_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
      end
   end

   assign INPR = inpr_q;
   assign FGI  = fgi_q;
   assign OVR  = ovr_q;
   assign FERR = ferr_q;
   assign BUSY = busy_q;

endmodule

// File: tb/tb_inpr_uart_rx.sv
// Scoreboard bench for inpr_uart_rx: stimulus pushes expected register updates
// (value and edge number); a negedge monitor pops one entry per observed output change.
module tb_inpr_uart_rx;

   localparam int CPB        = 16;
   localparam int STOP_EDGE  = 2 + CPB / 2 + 9 * CPB;  // edges from first low RX edge to stop sample
   localparam int FRAME_CYCS = 10 * CPB;

   typedef struct packed {
      logic [7:0] inpr;
      logic       fgi;
      logic       ovr;
      logic       ferr;
   } obs_t;

   typedef struct {
      int unsigned cyc;
      obs_t        s;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       RX;
   logic       FGI_CLR;
   logic [7:0] INPR;
   logic       FGI;
   logic       OVR;
   logic       FERR;
   logic       BUSY;

   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;
   bit          mon_en   = 1'b0;
   obs_t        model    = '0;
   obs_t        last_obs = '0;
   obs_t        mon_cur;
   exp_t        mon_e;
   exp_t        exp_q[$];

   inpr_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk     (clk),
      .rst     (rst),
      .RX      (RX),
      .FGI_CLR (FGI_CLR),
      .INPR    (INPR),
      .FGI     (FGI),
      .OVR     (OVR),
      .FERR    (FERR),
      .BUSY    (BUSY)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference behaviour of one completed frame on the register bank.
   function automatic obs_t ref_frame(obs_t s, logic [7:0] d, bit stop_ok, bit clr);
      obs_t r = s;
      if (!stop_ok) begin
         r.ferr = 1'b1;
      end else if (!s.fgi || clr) begin
         r.inpr = d;
         r.fgi  = 1'b1;
         if (clr) begin
            r.ovr  = 1'b0;
            r.ferr = 1'b0;
         end
      end else begin
         r.ovr = 1'b1;
      end
      return r;
   endfunction

   task automatic expect_state(input int unsigned at, input obs_t nxt);
      exp_t e;
      if (nxt !== model) begin
         e.cyc = at;
         e.s   = nxt;
         exp_q.push_back(e);
      end
      model = nxt;
   endtask

   task automatic tick(input logic rx_v, input logic clr_v);
      RX      = rx_v;
      FGI_CLR = clr_v;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit clr_at_stop);
      int unsigned k;
      logic        b;
      k = cyc + 1;
      expect_state(k + STOP_EDGE, ref_frame(model, d, stop_ok, clr_at_stop));
      for (int c = 0; c < FRAME_CYCS; c++) begin
         if (c < CPB)          b = 1'b0;
         else if (c < 9 * CPB) b = d[(c / CPB) - 1];
         else                  b = stop_ok;
         tick(b, clr_at_stop && (c == STOP_EDGE));
      end
   endtask

   task automatic pulse_clear();
      obs_t n = model;
      n.fgi  = 1'b0;
      n.ovr  = 1'b0;
      n.ferr = 1'b0;
      expect_state(cyc + 1, n);
      tick(1'b1, 1'b1);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon_cur = {INPR, FGI, OVR, FERR};
         if (mon_cur !== last_obs) begin
            if (exp_q.size() == 0) begin
               check("unexpected_change", 32'(mon_cur), 32'(last_obs));
            end else begin
               mon_e = exp_q.pop_front();
               check("outputs", 32'(mon_cur), 32'(mon_e.s));
               check("update_edge", 32'(cyc), 32'(mon_e.cyc));
            end
            last_obs = mon_cur;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      bit         ok;
      bit         clr;
      int unsigned k;

      rst     = 1'b1;
      RX      = 1'b1;
      FGI_CLR = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_inpr", 32'(INPR), 32'h00);
      check("reset_fgi",  32'(FGI),  32'h0);
      check("reset_ovr",  32'(OVR),  32'h0);
      check("reset_ferr", 32'(FERR), 32'h0);
      check("reset_busy", 32'(BUSY), 32'h0);
      model    = '0;
      last_obs = '0;
      mon_en   = 1'b1;
      idle(5);

      // Normal frame and acknowledge.
      send_frame(8'hA5, 1'b1, 1'b0);
      idle(4);
      check("busy_after_frame", 32'(BUSY), 32'h0);
      pulse_clear();
      idle(4);

      // Overrun: second character discarded.
      send_frame(8'h3C, 1'b1, 1'b0);
      idle(3);
      send_frame(8'hC3, 1'b1, 1'b0);
      idle(3);
      pulse_clear();
      idle(4);

      // Framing error followed by a held break.
      send_frame(8'h55, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) tick(1'b0, 1'b0);
      check("busy_in_break", 32'(BUSY), 32'h1);
      tick(1'b1, 1'b0);
      check("busy_release_edge", 32'(BUSY), 32'h1);
      idle(4);
      check("busy_after_break", 32'(BUSY), 32'h0);
      send_frame(8'h12, 1'b1, 1'b0);
      idle(3);
      pulse_clear();
      idle(4);

      // Glitch shorter than half a bit.
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
      check("busy_glitch_start", 32'(BUSY), 32'h1);
      idle(20);
      check("busy_glitch_end", 32'(BUSY), 32'h0);

      // Acknowledge on the exact stop-sample edge of the next character.
      send_frame(8'h01, 1'b1, 1'b0);
      idle(3);
      send_frame(8'h02, 1'b1, 1'b1);
      idle(4);

      // Reset during data bit 4 of 0xFF with the line high.
      k = cyc + 1;
      for (int c = 0; c < 88; c++) tick((c < CPB) ? 1'b0 : 1'b1, 1'b0);
      expect_state(k + 88, '0);
      rst = 1'b1;
      tick(1'b1, 1'b0);
      rst = 1'b0;
      check("busy_after_rst", 32'(BUSY), 32'h0);
      idle(20);
      check("busy_idle_after_rst", 32'(BUSY), 32'h0);
      send_frame(8'h81, 1'b1, 1'b0);
      idle(4);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 16; n++) begin
         d   = 8'($urandom);
         ok  = ($urandom_range(0, 5) != 0);
         clr = ok && ($urandom_range(0, 3) == 0);
         send_frame(d, ok, clr);
         idle($urandom_range(4, 10));
         if ($urandom_range(0, 1) == 1) begin
            pulse_clear();
            idle(2);
         end
      end

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1'b1, 1'b0);
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      check("final_inpr", 32'(INPR), 32'(model.inpr));
      check("final_flags", 32'({FGI, OVR, FERR}), 32'({model.fgi, model.ovr, model.ferr}));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
